// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the execute-stage multiply/divide sequencer.
// State encoding, divider iteration count and the conditional negate helpers.
package muldiv_pkg;

  localparam int DATA_W     = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Two's-complement negate when neg is set; used for operand magnitudes and result sign fix.
  function automatic logic [DATA_W-1:0] sign_fix32(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] sign_fix64(input logic [2*DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// E-stage operand/command bundle and HI/LO result bundle for muldiv_ctrl.
// The pipeline side drives through master; the sequencer takes slave.
interface muldiv_ctrl_if;

  logic                          mul_startE;
  logic                          div_startE;
  logic                          signedE;
  logic [muldiv_pkg::DATA_W-1:0] srcaE;
  logic [muldiv_pkg::DATA_W-1:0] srcbE;
  logic                          flush_except;
  logic                          mut_div_stallE;
  logic [muldiv_pkg::DATA_W-1:0] hi_o;
  logic [muldiv_pkg::DATA_W-1:0] lo_o;
  logic                          result_validE;

  modport master (
    output mul_startE, div_startE, signedE, srcaE, srcbE, flush_except,
    input  mut_div_stallE, hi_o, lo_o, result_validE
  );

  modport slave (
    input  mul_startE, div_startE, signedE, srcaE, srcbE, flush_except,
    output mut_div_stallE, hi_o, lo_o, result_validE
  );

endinterface

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring-division step: shift the partial remainder left, trial-subtract
// the divisor from the upper half and shift in the resulting quotient bit.
module div_step
  import muldiv_pkg::*;
(
  input  logic [2*DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0]   divisor_i,
  output logic [2*DATA_W-1:0] rem_o,
  output logic                q_o
);

  // Upper half after the shift needs one extra bit; the difference one more for the borrow.
  logic [DATA_W:0]   top_d;
  logic [DATA_W+1:0] diff_d;

  always_comb begin
    top_d  = rem_i[2*DATA_W-1:DATA_W-1];
    diff_d = {1'b0, top_d} - {2'b00, divisor_i};
    q_o    = ~diff_d[DATA_W+1];
    if (q_o) begin
      rem_o = {diff_d[DATA_W-1:0], rem_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o = {rem_i[2*DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer for the E stage: 2-cycle multiply, 32-step restoring divide,
// stall to the hazard unit until HI/LO is ready. Optional MULDIV_DIV_ZERO_FAST_EN short-cuts x/0.
module muldiv_ctrl #(
  parameter int DIV_CYCLES = muldiv_pkg::DIV_CYCLES
) (
  input  logic          clk,
  input  logic          resetn,
  muldiv_ctrl_if.slave  bus
);

  import muldiv_pkg::*;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIV_CYCLES - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_W-1:0]       a_q;
  logic [DATA_W-1:0]       b_q;
  logic [2*DATA_W-1:0]     rem_q;
  logic                    sign_q;
  logic                    sign_r_q;
  logic [DATA_W-1:0]       hi_q;
  logic [DATA_W-1:0]       lo_q;
  logic                    valid_q;

  logic                    neg_a_d;
  logic                    neg_b_d;
  logic [DATA_W-1:0]       a_mag_d;
  logic [DATA_W-1:0]       b_mag_d;
  logic [2*DATA_W-1:0]     prod_d;
  logic [2*DATA_W-1:0]     rem_d;
  logic                    qbit_d;
  logic                    div_zero_fast_d;

  assign neg_a_d = bus.signedE & bus.srcaE[DATA_W-1];
  assign neg_b_d = bus.signedE & bus.srcbE[DATA_W-1];
  assign a_mag_d = sign_fix32(bus.srcaE, neg_a_d);
  assign b_mag_d = sign_fix32(bus.srcbE, neg_b_d);
  assign prod_d  = (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);

`ifdef MULDIV_DIV_ZERO_FAST_EN
  assign div_zero_fast_d = (bus.srcbE == '0);
`else
  assign div_zero_fast_d = 1'b0;
`endif

  div_step u_div_step (
    .rem_i     (rem_q),
    .divisor_i (b_q),
    .rem_o     (rem_d),
    .q_o       (qbit_d)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      sign_r_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      valid_q  <= 1'b0;
    end else if (bus.flush_except) begin
      // Abandon whatever is in flight; HI/LO keep the last completed result.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.div_startE && div_zero_fast_d) begin
            hi_q    <= bus.srcaE;
            lo_q    <= '1;
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else if (bus.div_startE || bus.mul_startE) begin
            a_q      <= a_mag_d;
            b_q      <= b_mag_d;
            rem_q    <= {{DATA_W{1'b0}}, a_mag_d};
            sign_q   <= neg_a_d ^ neg_b_d;
            sign_r_q <= neg_a_d;
            cnt_q    <= '0;
            state_q  <= bus.div_startE ? ST_DIV_RUN : ST_MUL_RUN;
          end
        end

        ST_MUL_RUN: begin
          {hi_q, lo_q} <= sign_fix64(prod_d, sign_q);
          valid_q      <= 1'b1;
          state_q      <= ST_DONE;
        end

        ST_DIV_RUN: begin
          rem_q <= rem_d;
          if (cnt_q == LAST_ITER) begin
            // Final step: quotient sits in the low half, remainder in the high half.
            lo_q    <= sign_fix32({rem_d[DATA_W-1:1], qbit_d}, sign_q);
            hi_q    <= sign_fix32(rem_d[2*DATA_W-1:DATA_W], sign_r_q);
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          // Start is still asserted here because the instruction has not left E yet.
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mut_div_stallE = resetn & ~bus.flush_except &
                              (((state_q == ST_IDLE) & (bus.mul_startE | bus.div_startE)) |
                               (state_q == ST_MUL_RUN) | (state_q == ST_DIV_RUN));
  assign bus.hi_o           = hi_q;
  assign bus.lo_o           = lo_q;
  assign bus.result_validE  = valid_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table through a scoreboard queue,
// plus hand-written flush and mid-operation reset sequences.
module tb_muldiv_ctrl;

  logic clk;
  logic resetn;

  muldiv_ctrl_if bus ();

  muldiv_ctrl u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_DIV_ZERO_FAST_EN
  localparam int DZ_STALL = 1;
`else
  localparam int DZ_STALL = 33;
`endif

  typedef struct {
    string       name;
    bit          is_mul;
    bit          is_div;
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sb_q [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int   stalls;
    bit   seen;
    exp_t e;
    sb_q.push_back('{v.name, v.hi, v.lo, v.stalls});
    @(posedge clk); #1;
    bus.mul_startE = v.is_mul;
    bus.div_startE = v.is_div;
    bus.signedE    = v.sgn;
    bus.srcaE      = v.a;
    bus.srcbE      = v.b;
    stalls = 0;
    seen   = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (bus.result_validE === 1'b1) seen = 1'b1;
      else if (bus.mut_div_stallE === 1'b1) stalls++;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no result_validE expected one within 100 cycles", e.name);
    end else begin
      $display("op %s a=%h b=%h hi=%h lo=%h stalls=%0d", e.name, v.a, v.b, bus.hi_o, bus.lo_o, stalls);
      chk({e.name, "_hi"}, bus.hi_o, e.hi);
      chk({e.name, "_lo"}, bus.lo_o, e.lo);
      chk({e.name, "_stalls"}, 32'(stalls), 32'(e.stalls));
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(posedge clk); #1;
    bus.mul_startE = 1'b0;
    bus.div_startE = 1'b0;
    @(negedge clk);
    chk({e.name, "_valid_one_cycle"}, 32'(bus.result_validE), 32'd0);
  endtask

  initial begin
    int vcount;

    vecs[0] = '{"MULTU_max",     1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    vecs[1] = '{"MULT_m3x5",     1, 0, 1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 2};
    vecs[2] = '{"MULT_m1xm1",    1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 2};
    vecs[3] = '{"MULT_minx2",    1, 0, 1, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, 2};
    vecs[4] = '{"MULTU_2p16sq",  1, 0, 0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 2};
    vecs[5] = '{"DIV_m7d2",      0, 1, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[6] = '{"DIVU_100d7",    0, 1, 0, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[7] = '{"DIV_7dm2",      0, 1, 1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[8] = '{"DIVU_maxd1",    0, 1, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33};
    vecs[9] = '{"DIVU_5d0",      0, 1, 0, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DZ_STALL};
    vcount = 10;

    // Reset with a start pending: stall must stay low while resetn is low.
    resetn           = 1'b0;
    bus.mul_startE   = 1'b0;
    bus.div_startE   = 1'b1;
    bus.signedE      = 1'b0;
    bus.srcaE        = 32'd1;
    bus.srcbE        = 32'd1;
    bus.flush_except = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_stall", 32'(bus.mut_div_stallE), 32'd0);
    bus.div_startE = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_hi", bus.hi_o, 32'h0);
    chk("reset_lo", bus.lo_o, 32'h0);
    chk("reset_valid", 32'(bus.result_validE), 32'd0);
    chk("reset_idle_stall", 32'(bus.mut_div_stallE), 32'd0);

    for (int i = 0; i < vcount; i++) run_op(vecs[i]);

    // Flush during iteration 10 of a divide.
    begin
      int valids;
      @(posedge clk); #1;
      bus.div_startE = 1'b1;
      bus.signedE    = 1'b0;
      bus.srcaE      = 32'd1000;
      bus.srcbE      = 32'd3;
      repeat (11) @(posedge clk);
      #1;
      bus.flush_except = 1'b1;
      @(negedge clk);
      chk("flush_stall_drop", 32'(bus.mut_div_stallE), 32'd0);
      @(posedge clk); #1;
      bus.flush_except = 1'b0;
      bus.div_startE   = 1'b0;
      valids = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.result_validE === 1'b1) valids++;
      end
      $display("op flush_div valids=%0d hi=%h lo=%h", valids, bus.hi_o, bus.lo_o);
      chk("flush_no_valid", 32'(valids), 32'd0);
      chk("flush_hi_kept", bus.hi_o, last_hi);
      chk("flush_lo_kept", bus.lo_o, last_lo);
    end

    // A full divide right after the flush proves the unit went back to IDLE.
    run_op('{"DIVU_after_flush", 0, 1, 0, 32'd1000, 32'd3, 32'd1, 32'd333, 33});

    // Asynchronous reset at iteration 20 of a divide.
    @(posedge clk); #1;
    bus.div_startE = 1'b1;
    bus.signedE    = 1'b0;
    bus.srcaE      = 32'd100;
    bus.srcbE      = 32'd7;
    repeat (21) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    $display("op reset_mid_div hi=%h lo=%h stall=%0b", bus.hi_o, bus.lo_o, bus.mut_div_stallE);
    chk("midreset_hi", bus.hi_o, 32'h0);
    chk("midreset_lo", bus.lo_o, 32'h0);
    chk("midreset_stall", 32'(bus.mut_div_stallE), 32'd0);
    chk("midreset_valid", 32'(bus.result_validE), 32'd0);
    @(posedge clk); #1;
    bus.div_startE = 1'b0;
    resetn         = 1'b1;

    run_op('{"DIVU_9d3_after_reset", 0, 1, 0, 32'd9, 32'd3, 32'd0, 32'd3, 33});

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the execute-stage multiply/divide unit. Accepts MULT/MULTU/DIV/DIVU from the E stage, runs a 2-cycle registered multiplier or a 32-iteration restoring divider, and drives `mut_div_stallE` into the hazard unit until the HI/LO result is ready. Sits beside the ALU in E. Its results feed the HI/LO register write in M.

## Interface
- `DIV_CYCLES`, default 32: number of divider iterations. Fixed at the data width.
- `clk` in, 1 bit: pipeline clock.
- `resetn` in, 1 bit: reset, asynchronous and active-low.
- `mul_startE` in, 1 bit: the E-stage instruction is MULT/MULTU.
- `div_startE` in, 1 bit: the E-stage instruction is DIV/DIVU.
- `signedE` in, 1 bit: signed variant (MULT/DIV).
- `srcaE` in, 32 bits: rs operand, after forwarding.
- `srcbE` in, 32 bits: rt operand, after forwarding.
- `flush_except` in, 1 bit: exception flush. Cancels any operation in flight.
- `mut_div_stallE` out, 1 bit: stall request to the hazard unit.
- `hi_o` out, 32 bits: HI result (remainder, or product[63:32]).
- `lo_o` out, 32 bits: LO result (quotient, or product[31:0]).
- `result_validE` out, 1 bit: `hi_o`/`lo_o` are valid this cycle.

## Operation
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE:
  - `mul_startE & !flush_except` → latch the operands, go to MUL_RUN.
  - `div_startE & !flush_except` → latch the operands, go to DIV_RUN.
  - Both start inputs high is illegal. div takes priority.
- Signed ops: latch |srcaE| and |srcbE|. Record `sign_q = sa^sb` and `sign_r = sa`.
- MUL_RUN: one cycle. 32x32 magnitude product is registered, then go to DONE. In DONE, negate the 64-bit product when `sign_q`.
- DIV_RUN: restoring division, one quotient bit per cycle, MSB first.
  - Registers: 64-bit partial remainder, 6-bit counter cleared on entry.
  - Go to DONE when the counter reaches `DIV_CYCLES-1`.
  - Apply sign correction in DONE: quotient negated when `sign_q`, remainder negated when `sign_r`.
  - Example: -7/2 → LO=-3, HI=-1.
- DONE: `result_validE=1` for exactly one cycle, then IDLE.
  - The start input is still high in DONE, because the instruction has not yet left E. It must not restart the unit.
- `mut_div_stallE = ((IDLE & (mul_startE|div_startE)) | MUL_RUN | DIV_RUN) & !flush_except`. It is combinational.
- `flush_except` in any state → IDLE on the next edge. No `result_validE`. Latched operands and results are discarded.
- Divide by zero, without the feature (see Configuration):
  - Runs the full 32 iterations.
  - Magnitude quotient = 0xFFFFFFFF, magnitude remainder = |a|, then normal sign correction.

## Timing
- Reset values: state=IDLE, counter=0, `hi_o`=`lo_o`=0, `result_validE`=0. `mut_div_stallE`=0 while `resetn` is low.
- `hi_o`/`lo_o` hold their last DONE value until the next DONE. They are not cleared on flush.
- MUL: stall is high in the issue cycle and in MUL_RUN (2 cycles). DONE is the 3rd cycle, and the instruction leaves E at the end of DONE.
- DIV: stall is high in the issue cycle plus 32 DIV_RUN cycles (33 cycles). DONE is the 34th cycle.
- Back-to-back mul/div: the second op is seen in IDLE on the cycle after DONE. There are no bubbles beyond that.
- `resetn` asserted mid-operation → IDLE immediately (asynchronous). There is no partial result.

## Configuration
- `MULDIV_DIV_ZERO_FAST_EN` defined:
  - In IDLE, `div_startE & srcbE==0` → DONE directly, skipping DIV_RUN.
  - `hi_o`=srcaE, `lo_o`=0xFFFFFFFF, with no sign correction.
  - Stall is high for the issue cycle only.
- Not defined: divide by zero takes the full 33-cycle path and produces the result described in Operation.

## Structure
- Shared package `muldiv_pkg`:
  - State encoding (2-bit constants: IDLE=0, MUL_RUN=1, DIV_RUN=2, DONE=3).
  - `DIV_CYCLES`.
  - Sign-fix helper function (conditional two's-complement negate).
- One sub-module, `div_step`: combinational single restoring step.
  - Input: 64-bit remainder and 32-bit divisor.
  - Output: next remainder and quotient bit.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Stall high exactly 2 cycles; valid in the 3rd cycle.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2. Stall high 33 cycles, valid 1 cycle.
- DIVU 5/0:
  - Macro off → LO=0xFFFFFFFF, HI=5 after 33 stall cycles.
  - Macro on → same values after 1 stall cycle.
- DIV in flight, `flush_except` at iteration 10 → stall drops that cycle, IDLE next cycle, no valid. `hi_o`/`lo_o` unchanged.
- `resetn` low at iteration 20 → IDLE, `hi_o`=`lo_o`=0, stall 0. A new DIVU 9/3 after reset → LO=3, HI=0.
